// File: rtl/mem_channel_controller.sv
// mem_channel_controller: arbitrates per-consumer memory requests onto NUM_CHANNELS external channels.
// Each channel claims one consumer, forwards its request, and relays the result back with valid/ready.
module mem_channel_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CONSUMERS-1:0]               consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]     consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]               consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]     consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]               consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]     consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]     consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]               consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]      mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]      mem_read_data,
    output logic [NUM_CHANNELS-1:0]                mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]      mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]      mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                mem_write_ready
);
    localparam int IW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [2:0] IDLE           = 3'd0;
    localparam logic [2:0] READ_WAITING   = 3'd1;
    localparam logic [2:0] WRITE_WAITING  = 3'd2;
    localparam logic [2:0] READ_RELAYING  = 3'd3;
    localparam logic [2:0] WRITE_RELAYING = 3'd4;

    logic [2:0]                          state [NUM_CHANNELS];
    logic [IW-1:0]                       idx [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]            claim;
    logic [NUM_CONSUMERS-1:0]            want;
    logic [NUM_CHANNELS-1:0]             pick_ok;
    logic [NUM_CHANNELS-1:0]             pick_rd;
    logic [IW-1:0]                       pick_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]             wr_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]   wr_addr;
    logic [NUM_CHANNELS*DATA_BITS-1:0]   wr_data;
    logic [NUM_CONSUMERS-1:0]            wr_ready;

    assign want = consumer_read_valid | (consumer_write_valid & {NUM_CONSUMERS{WRITE_ENABLE != 0}});

    // Lower channels pick first; a consumer picked by one channel is hidden from the ones above it.
    always_comb begin : arbiter
        logic [NUM_CONSUMERS-1:0] taken;
        taken   = claim;
        pick_ok = '0;
        pick_rd = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            pick_idx[c] = '0;
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                if (state[c] == IDLE && !pick_ok[c] && !taken[k] && want[k]) begin
                    pick_ok[c]  = 1'b1;
                    pick_idx[c] = IW'(k);
                    pick_rd[c]  = consumer_read_valid[k];
                end
            end
            if (pick_ok[c]) taken[pick_idx[c]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                idx[c]   <= '0;
            end
            claim               <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            wr_ready            <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            wr_valid            <= '0;
            wr_addr             <= '0;
            wr_data             <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: begin
                        if (pick_ok[c]) begin
                            claim[pick_idx[c]] <= 1'b1;
                            idx[c]             <= pick_idx[c];
                            if (pick_rd[c]) begin
                                mem_read_valid[c] <= 1'b1;
                                mem_read_address[c*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_read_address[pick_idx[c]*ADDR_BITS +: ADDR_BITS];
                                state[c] <= READ_WAITING;
                            end else begin
                                wr_valid[c] <= 1'b1;
                                wr_addr[c*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_write_address[pick_idx[c]*ADDR_BITS +: ADDR_BITS];
                                wr_data[c*DATA_BITS +: DATA_BITS] <=
                                    consumer_write_data[pick_idx[c]*DATA_BITS +: DATA_BITS];
                                state[c] <= WRITE_WAITING;
                            end
                        end
                    end
                    READ_WAITING: begin
                        if (mem_read_ready[c]) begin
                            mem_read_valid[c] <= 1'b0;
                            consumer_read_data[idx[c]*DATA_BITS +: DATA_BITS] <=
                                mem_read_data[c*DATA_BITS +: DATA_BITS];
                            consumer_read_ready[idx[c]] <= 1'b1;
                            state[c] <= READ_RELAYING;
                        end
                    end
                    WRITE_WAITING: begin
                        if (mem_write_ready[c]) begin
                            wr_valid[c]      <= 1'b0;
                            wr_ready[idx[c]] <= 1'b1;
                            state[c]         <= WRITE_RELAYING;
                        end
                    end
                    READ_RELAYING: begin
                        if (!consumer_read_valid[idx[c]]) begin
                            consumer_read_ready[idx[c]] <= 1'b0;
                            claim[idx[c]]               <= 1'b0;
                            state[c]                    <= IDLE;
                        end
                    end
                    WRITE_RELAYING: begin
                        if (!consumer_write_valid[idx[c]]) begin
                            wr_ready[idx[c]] <= 1'b0;
                            claim[idx[c]]    <= 1'b0;
                            state[c]         <= IDLE;
                        end
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end

    assign mem_write_valid      = WRITE_ENABLE != 0 ? wr_valid : '0;
    assign mem_write_address    = WRITE_ENABLE != 0 ? wr_addr  : '0;
    assign mem_write_data       = WRITE_ENABLE != 0 ? wr_data  : '0;
    assign consumer_write_ready = WRITE_ENABLE != 0 ? wr_ready : '0;
endmodule

// File: tb/tb_mem_channel_controller.sv
// tb_mem_channel_controller: scoreboard bench for a 2-channel read/write controller
// and a 1-channel read-only instance, with a latency-programmable memory responder.
module tb_mem_channel_controller;
    typedef struct packed {
        logic        w;
        logic [7:0]  a;
        logic [15:0] d;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  crv, cwv, crr, cwr;
    logic [31:0] cra, cwa;
    logic [63:0] cwd, crd;
    logic [1:0]  mrv, mrr, mwv, mwr;
    logic [15:0] mra, mwa;
    logic [31:0] mrd, mwd;

    logic [3:0]  ro_crv, ro_cwv, ro_crr, ro_cwr;
    logic [31:0] ro_cra, ro_cwa;
    logic [63:0] ro_cwd, ro_crd;
    logic        ro_mrv, ro_mrr, ro_mwv, ro_mwr;
    logic [7:0]  ro_mra, ro_mwa;
    logic [15:0] ro_mrd, ro_mwd;

    mem_channel_controller #(.NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(crv), .consumer_read_address(cra),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(cwv), .consumer_write_address(cwa),
        .consumer_write_data(cwd), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
    );

    mem_channel_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset),
        .consumer_read_valid(ro_crv), .consumer_read_address(ro_cra),
        .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
        .consumer_write_valid(ro_cwv), .consumer_write_address(ro_cwa),
        .consumer_write_data(ro_cwd), .consumer_write_ready(ro_cwr),
        .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
        .mem_read_ready(ro_mrr), .mem_read_data(ro_mrd),
        .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa),
        .mem_write_data(ro_mwd), .mem_write_ready(ro_mwr)
    );

    int compared = 0;
    int mismatched = 0;
    int lat = 0;
    int cnt [2];
    int exp_wr [4];
    logic [15:0] exp_rd [4][$];
    req_t exp_ch [2][$];
    logic [15:0] mem [256];
    logic [255:0] written = '0;

    function automatic logic [15:0] mem_rd(input logic [7:0] a);
        return written[a] ? mem[a] : (a == 8'h10 ? 16'hBEEF : {~a, a});
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Memory model: answers each channel request after `lat` idle negedges.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (mrr[c]) mrr[c] = 1'b0;
            else if (mwr[c]) mwr[c] = 1'b0;
            else if (mrv[c] || mwv[c]) begin
                if (cnt[c] >= lat) begin
                    cnt[c] = 0;
                    if (mrv[c]) begin
                        mrr[c] = 1'b1;
                        mrd[c*16 +: 16] = mem_rd(mra[c*8 +: 8]);
                    end else begin
                        mwr[c] = 1'b1;
                        mem[mwa[c*8 +: 8]] = mwd[c*16 +: 16];
                        written[mwa[c*8 +: 8]] = 1'b1;
                    end
                end else cnt[c]++;
            end else cnt[c] = 0;
        end
        if (ro_mrr) ro_mrr = 1'b0;
        else if (ro_mrv) begin
            ro_mrr = 1'b1;
            ro_mrd = mem_rd(ro_mra);
        end
    end

    logic [3:0] prr = '0, pwr = '0;
    logic [1:0] pmr = '0, pmw = '0;
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (crr[k] && !prr[k]) begin
                if (exp_rd[k].size() == 0) chk($sformatf("rd_unexpected%0d", k), 32'(crd[k*16 +: 16]), 32'hFFFF_FFFF);
                else chk($sformatf("rd_data%0d", k), 32'(crd[k*16 +: 16]), 32'(exp_rd[k].pop_front()));
            end
            if (cwr[k] && !pwr[k]) begin
                chk($sformatf("wr_ack%0d", k), 32'(exp_wr[k] > 0), 32'd1);
                if (exp_wr[k] > 0) exp_wr[k]--;
            end
        end
        for (int c = 0; c < 2; c++) begin
            if ((mrv[c] && !pmr[c]) || (mwv[c] && !pmw[c])) begin
                req_t act, e;
                act.w = mwv[c];
                act.a = mwv[c] ? mwa[c*8 +: 8] : mra[c*8 +: 8];
                act.d = mwv[c] ? mwd[c*16 +: 16] : 16'h0;
                e = exp_ch[c].size() > 0 ? exp_ch[c].pop_front() : '1;
                chk($sformatf("ch%0d_req", c), 32'(act), 32'(e));
            end
        end
        if (|(crr | cwr)) chk("claims", 32'(($countones(crr | cwr) <= 2) && ((crr & cwr) == 0)), 32'd1);
        prr = crr; pwr = cwr; pmr = mrv; pmw = mwv;
    end

    task automatic rd(input int k, input logic [7:0] a);
        int n = 0;
        exp_rd[k].push_back(mem_rd(a));
        crv[k] = 1'b1;
        cra[k*8 +: 8] = a;
        while (!crr[k] && n < 300) begin @(posedge clk); #1; n++; end
        chk($sformatf("rd_timeout%0d", k), 32'(n < 300), 32'd1);
        crv[k] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("rd_release%0d", k), 32'(crr[k]), 32'd0);
    endtask

    task automatic wr(input int k, input logic [7:0] a, input logic [15:0] d);
        int n = 0;
        exp_wr[k]++;
        cwv[k] = 1'b1;
        cwa[k*8 +: 8] = a;
        cwd[k*16 +: 16] = d;
        while (!cwr[k] && n < 300) begin @(posedge clk); #1; n++; end
        chk($sformatf("wr_timeout%0d", k), 32'(n < 300), 32'd1);
        cwv[k] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("wr_release%0d", k), 32'(cwr[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
        mrr = '0; mwr = '0; mrd = '0;
        ro_crv = '0; ro_cwv = '0; ro_cra = '0; ro_cwa = '0; ro_cwd = '0;
        ro_mrr = 1'b0; ro_mwr = 1'b0; ro_mrd = '0;
        cnt[0] = 0; cnt[1] = 0;
        for (int k = 0; k < 4; k++) exp_wr[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_crr", 32'(crr), 0);
        chk("rst_cwr", 32'(cwr), 0);
        chk("rst_mrv", 32'(mrv), 0);
        chk("rst_mwv", 32'(mwv), 0);
        chk("rst_crd", 32'(crd[31:0] | crd[63:32]), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single read with 3-cycle memory latency
        lat = 3;
        exp_ch[0].push_back('{1'b0, 8'h10, 16'h0});
        fork
            rd(2, 8'h10);
            begin
                @(posedge clk); #1;
                chk("rd_issue_v", 32'(mrv[0]), 1);
                chk("rd_issue_a", 32'(mra[7:0]), 32'h10);
            end
        join
        chk("rd_beef_held", 32'(crd[47:32]), 32'hBEEF);

        // Single write, immediate memory ack
        lat = 0;
        exp_ch[0].push_back('{1'b1, 8'h05, 16'h00AA});
        fork
            wr(0, 8'h05, 16'h00AA);
            begin
                @(posedge clk); #1;
                chk("wr_issue_v", 32'(mwv[0]), 1);
                chk("wr_issue_ad", {8'h0, mwa[7:0], mwd[15:0]}, 32'h0005_00AA);
                @(posedge clk); #1;
                chk("wr_drop_v", 32'(mwv[0]), 0);
            end
        join
        chk("mem05", 32'(mem_rd(8'h05)), 32'h00AA);

        // Contention: four reads at once on two channels
        lat = 2;
        exp_ch[0].push_back('{1'b0, 8'h50, 16'h0});
        exp_ch[0].push_back('{1'b0, 8'h52, 16'h0});
        exp_ch[1].push_back('{1'b0, 8'h51, 16'h0});
        exp_ch[1].push_back('{1'b0, 8'h53, 16'h0});
        fork
            rd(0, 8'h50);
            rd(1, 8'h51);
            rd(2, 8'h52);
            rd(3, 8'h53);
        join

        // Read and write from the same consumer: read goes first
        lat = 1;
        exp_ch[0].push_back('{1'b0, 8'h30, 16'h0});
        exp_ch[0].push_back('{1'b1, 8'h31, 16'h1234});
        fork
            rd(1, 8'h30);
            wr(1, 8'h31, 16'h1234);
        join
        chk("mem31", 32'(mem_rd(8'h31)), 32'h1234);

        // Reset while a read is waiting on slow memory
        lat = 1000;
        exp_ch[0].push_back('{1'b0, 8'h20, 16'h0});
        crv[3] = 1'b1;
        cra[31:24] = 8'h20;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_mrv", 32'(mrv[0]), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_mrv", 32'(mrv), 0);
        chk("midrst_crr", 32'(crr), 0);
        chk("midrst_cwr", 32'(cwr | 4'(mwv)), 0);
        crv[3] = 1'b0;
        reset = 1'b0;
        lat = 1;
        exp_ch[0].push_back('{1'b0, 8'h22, 16'h0});
        rd(3, 8'h22);

        // Read-only instance: writes are never claimed, reads still work
        ro_cwv[0] = 1'b1;
        ro_cwa[7:0] = 8'h40;
        ro_cwd[15:0] = 16'h5555;
        repeat (6) begin
            @(posedge clk); #1;
            chk("ro_mwv", 32'(ro_mwv), 0);
            chk("ro_cwr", 32'(ro_cwr), 0);
        end
        ro_cwv[0] = 1'b0;
        ro_crv[0] = 1'b1;
        ro_cra[7:0] = 8'h12;
        begin
            int n = 0;
            while (!ro_crr[0] && n < 100) begin @(posedge clk); #1; n++; end
            chk("ro_rd_timeout", 32'(n < 100), 1);
        end
        chk("ro_rd_data", 32'(ro_crd[15:0]), 32'hED12);
        ro_crv[0] = 1'b0;
        @(posedge clk); #1;
        chk("ro_rd_release", 32'(ro_crr[0]), 0);

        repeat (5) @(posedge clk);
        #1;
        chk("ch0_left", exp_ch[0].size(), 0);
        chk("ch1_left", exp_ch[1].size(), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_left%0d", k), exp_rd[k].size(), 0);
            chk($sformatf("wr_left%0d", k), exp_wr[k], 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_channel_controller.md
Name: mem_channel_controller

Overview:
- Arbitrates per-thread data-memory requests from every core's LSUs onto a smaller number of external memory channels.
- Sits directly downstream of the core's data_mem_* ports, one consumer per thread slot across all cores, and upstream of the external memory.
- Each channel runs an independent FSM that claims one consumer, forwards its request, and relays the result back using the LSU valid/ready handshake.
- The same block with WRITE_ENABLE=0 serves program memory for the fetchers.

Parameters:
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 16, memory data width.
- NUM_CONSUMERS, 4, number of requesters (cores × threads).
- NUM_CHANNELS, 1, number of concurrent external memory channels (1..NUM_CONSUMERS).
- WRITE_ENABLE, 1, when 0, write ports are tied off and write requests are ignored.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  NUM_CONSUMERS×ADDR_BITS  read address.
- consumer_read_ready  out  NUM_CONSUMERS  read data valid / acknowledge.
- consumer_read_data  out  NUM_CONSUMERS×DATA_BITS  returned read data.
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
- consumer_write_address  in  NUM_CONSUMERS×ADDR_BITS  write address.
- consumer_write_data  in  NUM_CONSUMERS×DATA_BITS  write data.
- consumer_write_ready  out  NUM_CONSUMERS  write acknowledge.
- mem_read_valid  out  NUM_CHANNELS  channel read request.
- mem_read_address  out  NUM_CHANNELS×ADDR_BITS  channel read address.
- mem_read_ready  in  NUM_CHANNELS  memory read complete.
- mem_read_data  in  NUM_CHANNELS×DATA_BITS  memory read data.
- mem_write_valid  out  NUM_CHANNELS  channel write request.
- mem_write_address  out  NUM_CHANNELS×ADDR_BITS  channel write address.
- mem_write_data  out  NUM_CHANNELS×DATA_BITS  channel write data.
- mem_write_ready  in  NUM_CHANNELS  memory write complete.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset clears all outputs to 0, returns every channel to IDLE, clears the claim mask and zeroes the per-channel consumer index.
- Reset mid-transaction abandons it. No acknowledge is issued and the memory request drops on the next edge.
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - Scan consumers from index 0 upward for the first one that is not claimed and has read_valid, or write_valid with WRITE_ENABLE=1.
  - Read takes priority over write for the same consumer.
  - On a hit: set claim[k], record the index, latch address (and data for a write), assert mem_*_valid with the latched address/data, and go to *_WAITING.
  - All of this is registered, so mem_*_valid rises 1 cycle after the consumer valid is first seen.
- Same-cycle contention: lower-numbered channels pick first, and higher channels skip consumers already chosen in that cycle. No consumer is ever held by two channels.
- READ_WAITING:
  - Hold mem_read_valid/address until mem_read_ready=1.
  - Then drop mem_read_valid, drive consumer_read_data[k]=mem_read_data, assert consumer_read_ready[k] and go to READ_RELAYING.
  - Memory latency is unbounded.
- WRITE_WAITING: same as READ_WAITING, using mem_write_ready and consumer_write_ready[k].
- *_RELAYING:
  - Hold ready and data while the consumer's valid stays 1.
  - When the consumer valid is 0: drop ready, clear claim[k], return to IDLE.
  - Minimum consumer-visible round trip is valid→ready in 2 cycles with zero-wait memory.
- A claimed consumer cannot be re-arbitrated until its channel has returned to IDLE. A new request from it is served no earlier than the cycle after release.
- Consumer valid dropping during *_WAITING is a protocol violation. The controller still completes the memory transaction, then pulses ready for exactly 1 cycle in RELAYING.
- mem_*_ready inputs are ignored in every state except the matching *_WAITING.
- consumer_read_data[k] holds its last value after ready drops. Only ready qualifies it.
- WRITE_ENABLE=0: mem_write_valid, mem_write_address, mem_write_data and consumer_write_ready are constant 0. Write-only requests are never claimed.
- Fairness is not required beyond the fixed priority. Starvation of high indices under sustained load is accepted.

Test Plan:
- Single read: consumer 2 reads addr 0x10, memory returns 0xBEEF after 3 cycles → mem_read_valid rises 1 cycle after the request with address 0x10; consumer_read_ready[2]=1 with data 0xBEEF; ready falls 1 cycle after consumer valid drops.
- Single write: consumer 0 writes 0x00AA to 0x05, mem_write_ready immediate → mem_write_valid/0x05/0x00AA for 1 cycle; consumer_write_ready[0] asserted until valid drops; memory array holds 0x00AA.
- Contention: NUM_CHANNELS=2, all 4 consumers read in the same cycle → channel 0 takes consumer 0 and channel 1 takes consumer 1; consumers 2 and 3 are served only after the channels release; all four get correct data; there is never a duplicate claim.
- Read and write same consumer: consumer 1 asserts both → read is issued first; write is issued after the read completes and release occurs.
- Reset mid-operation: reset asserted while a channel is in READ_WAITING → next cycle all valid/ready outputs are 0 and the channel is IDLE; a fresh request afterwards completes normally.
- WRITE_ENABLE=0: only write requests asserted → no mem_write_valid ever, consumer_write_ready stays 0; a subsequent read still completes.
